// File: rtl/clock_divider_multi.sv
// NCH independent programmable clock dividers sharing one input clock.
// Settings are shadowed and applied only at period boundaries, so the outputs never glitch.
module clock_divider_multi #(
    parameter int NCH        = 4,
    parameter int DIV_W      = 16,
    parameter int DEF_PERIOD = 2500,
    parameter int DEF_HIGH   = 1250
) (
    input  logic                 clk_in_i,
    input  logic                 rst_i,
    input  logic [NCH-1:0]       en_i,
    input  logic [NCH-1:0]       load_i,
    input  logic [NCH*DIV_W-1:0] period_i,
    input  logic [NCH*DIV_W-1:0] high_i,
    input  logic                 sync_i,
    output logic [NCH-1:0]       clk_var_o,
    output logic [NCH-1:0]       tick_o,
    output logic [NCH-1:0]       pending_o
);

    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);
    localparam logic [DIV_W-1:0] DEF_P = DIV_W'(DEF_PERIOD);
    localparam logic [DIV_W-1:0] DEF_H = DIV_W'(DEF_HIGH);

    function automatic logic [DIV_W-1:0] clamp_p(input logic [DIV_W-1:0] p);
        return (p < TWO) ? TWO : p;
    endfunction

    // p must already be clamped, so p-1 is at least 1.
    function automatic logic [DIV_W-1:0] clamp_h(input logic [DIV_W-1:0] p,
                                                 input logic [DIV_W-1:0] h);
        if (h == '0)
            return ONE;
        else if (h >= p)
            return p - ONE;
        else
            return h;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            logic [DIV_W-1:0] cnt_q, cnt_d;
            logic [DIV_W-1:0] act_p_q, act_p_d, act_h_q, act_h_d;
            logic [DIV_W-1:0] shd_p_q, shd_p_d, shd_h_q, shd_h_d;
            logic [DIV_W-1:0] src_p, src_h, new_p;
            logic             pending_q, pending_d;
            logic             run_q, run_d;
            logic             clk_var_q, clk_var_d;
            logic             tick_q, tick_d;
            logic             boundary;

            always_ff @(posedge clk_in_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_q     <= '0;
                    act_p_q   <= DEF_P;
                    act_h_q   <= DEF_H;
                    shd_p_q   <= DEF_P;
                    shd_h_q   <= DEF_H;
                    pending_q <= 1'b0;
                    run_q     <= 1'b0;
                    clk_var_q <= 1'b0;
                    tick_q    <= 1'b0;
                end else begin
                    cnt_q     <= cnt_d;
                    act_p_q   <= act_p_d;
                    act_h_q   <= act_h_d;
                    shd_p_q   <= shd_p_d;
                    shd_h_q   <= shd_h_d;
                    pending_q <= pending_d;
                    run_q     <= run_d;
                    clk_var_q <= clk_var_d;
                    tick_q    <= tick_d;
                end
            end

            always_comb begin
                cnt_d     = cnt_q;
                act_p_d   = act_p_q;
                act_h_d   = act_h_q;
                shd_p_d   = shd_p_q;
                shd_h_d   = shd_h_q;
                pending_d = pending_q;
                run_d     = run_q;
                clk_var_d = clk_var_q;
                tick_d    = tick_q;

                // A LOAD in the boundary cycle bypasses the shadow and goes live directly.
                src_p = load_i[gi] ? period_i[gi*DIV_W +: DIV_W] : shd_p_q;
                src_h = load_i[gi] ? high_i[gi*DIV_W +: DIV_W]   : shd_h_q;
                new_p = clamp_p(src_p);

                // run_q low means the channel sits idle at CNT=0, so enabling it is a restart.
                boundary = !en_i[gi] || !run_q || sync_i || (cnt_q == act_p_q - ONE);

                if (load_i[gi]) begin
                    shd_p_d = period_i[gi*DIV_W +: DIV_W];
                    shd_h_d = high_i[gi*DIV_W +: DIV_W];
                end

                if (boundary) begin
                    cnt_d = '0;
                    if (load_i[gi] || pending_q) begin
                        act_p_d = new_p;
                        act_h_d = clamp_h(new_p, src_h);
                    end
                    pending_d = 1'b0;
                    run_d     = en_i[gi];
                    clk_var_d = en_i[gi];
                    tick_d    = en_i[gi];
                end else begin
                    cnt_d     = cnt_q + ONE;
                    clk_var_d = (cnt_d < act_h_q);
                    tick_d    = 1'b0;
                    if (load_i[gi])
                        pending_d = 1'b1;
                end
            end

            assign clk_var_o[gi] = clk_var_q;
            assign tick_o[gi]    = tick_q;
            assign pending_o[gi] = pending_q;
        end
    endgenerate

endmodule
